// File: rtl/reaction_core.sv
// rtl/reaction_core.sv - multi-player reaction-time game core
// Random pre-GO delay, per-player capture, winner selection and best-time tracking.
module reaction_core #(
  parameter int          N_PLAYERS  = 4,
  parameter int          TW         = 10,
  parameter int          TICK_DIV   = 50000,
  parameter int          DELAY_MIN  = 1000,
  parameter logic [15:0] DELAY_MASK = 16'h07FF
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    start,
  input  logic [N_PLAYERS-1:0]    press,
  output logic                    go,
  output logic [1:0]              state,
  output logic [N_PLAYERS*TW-1:0] react_time,
  output logic [N_PLAYERS-1:0]    valid,
  output logic [N_PLAYERS-1:0]    false_start,
  output logic [N_PLAYERS-1:0]    winner,
  output logic [TW-1:0]           win_time,
  output logic [TW-1:0]           best_time,
  output logic                    round_done
);

  localparam int          PW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int          DW   = 17;
  localparam logic [TW-1:0] TMAX = {TW{1'b1}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_GO = 2'd2, S_DONE = 2'd3} state_t;

  state_t                  state_q, state_d;
  logic                    go_q, go_d;
  logic                    round_done_q, round_done_d;
  logic [N_PLAYERS*TW-1:0] rt_q, rt_d;
  logic [N_PLAYERS-1:0]    valid_q, valid_d;
  logic [N_PLAYERS-1:0]    fs_q, fs_d;
  logic [N_PLAYERS-1:0]    winner_q, winner_d;
  logic [TW-1:0]           win_time_q, win_time_d;
  logic [TW-1:0]           best_q, best_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [DW-1:0]           delay_q, delay_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [15:0]             lfsr_q, lfsr_d;
  logic                    start_prev_q, start_prev_d;
  logic [N_PLAYERS-1:0]    press_prev_q, press_prev_d;
  logic                    armed_q, armed_d;

  logic                    start_edge, tick;
  logic [N_PLAYERS-1:0]    press_edge, caps;

  // A start held high across clear must be released before it can start a round.
  assign start_edge = start & ~start_prev_q & armed_q;
  assign press_edge = press & ~press_prev_q;
  assign tick       = (presc_q == PW'(TICK_DIV - 1));
  assign caps       = press_edge & ~valid_q & ~fs_q;

  always_comb begin
    state_d      = state_q;
    rt_d         = rt_q;
    valid_d      = valid_q;
    fs_d         = fs_q;
    winner_d     = winner_q;
    win_time_d   = win_time_q;
    best_d       = best_q;
    timer_d      = timer_q;
    delay_d      = delay_q;
    presc_d      = tick ? '0 : presc_q + PW'(1);
    lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    start_prev_d = start;
    press_prev_d = press;
    armed_d      = armed_q | ~start;
    round_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        if (start_edge) begin
          delay_d    = DW'(DELAY_MIN) + {1'b0, lfsr_q & DELAY_MASK};
          rt_d       = '0;
          valid_d    = '0;
          fs_d       = '0;
          winner_d   = '0;
          win_time_d = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        fs_d = fs_q | press_edge;
        if (&fs_d) begin
          state_d      = S_DONE;
          round_done_d = 1'b1;
        end else if (delay_q == '0 || (tick && delay_q == DW'(1))) begin
          state_d = S_GO;
          timer_d = '0;
          presc_d = '0;
        end else if (tick) begin
          delay_d = delay_q - DW'(1);
        end
      end
      S_GO: begin
        if (tick && timer_q != TMAX) timer_d = timer_q + TW'(1);
        for (int i = 0; i < N_PLAYERS; i++)
          if (caps[i]) rt_d[i*TW +: TW] = timer_q;
        valid_d = valid_q | caps;
        if (winner_q == '0 && caps != '0) begin
          winner_d   = caps & (~caps + N_PLAYERS'(1));
          win_time_d = timer_q;
        end
        if ((&(valid_d | fs_q)) || timer_q == TMAX) begin
          state_d      = S_DONE;
          round_done_d = 1'b1;
        end
      end
      S_DONE: begin
        if (winner_q != '0 && win_time_q < best_q) best_d = win_time_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    go_d = (state_d == S_GO);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q      <= S_IDLE;
      go_q         <= 1'b0;
      round_done_q <= 1'b0;
      rt_q         <= '0;
      valid_q      <= '0;
      fs_q         <= '0;
      winner_q     <= '0;
      win_time_q   <= '0;
      best_q       <= TMAX;
      timer_q      <= '0;
      delay_q      <= '0;
      presc_q      <= '0;
      lfsr_q       <= 16'hACE1;
      start_prev_q <= 1'b0;
      press_prev_q <= '0;
      armed_q      <= ~start;
    end else begin
      state_q      <= state_d;
      go_q         <= go_d;
      round_done_q <= round_done_d;
      rt_q         <= rt_d;
      valid_q      <= valid_d;
      fs_q         <= fs_d;
      winner_q     <= winner_d;
      win_time_q   <= win_time_d;
      best_q       <= best_d;
      timer_q      <= timer_d;
      delay_q      <= delay_d;
      presc_q      <= presc_d;
      lfsr_q       <= lfsr_d;
      start_prev_q <= start_prev_d;
      press_prev_q <= press_prev_d;
      armed_q      <= armed_d;
    end
  end

  assign go          = go_q;
  assign state       = state_q;
  assign react_time  = rt_q;
  assign valid       = valid_q;
  assign false_start = fs_q;
  assign winner      = winner_q;
  assign win_time    = win_time_q;
  assign best_time   = best_q;
  assign round_done  = round_done_q;

endmodule

// File: tb/tb_reaction_core.sv
// tb/tb_reaction_core.sv - bench for reaction_core
// Phase/offset model of the game compared every cycle, plus directed literal scenarios.
module tb_reaction_core;
  localparam int N    = 4;
  localparam int TW   = 10;
  localparam int TD   = 4;
  localparam int DMIN = 3;
  localparam int TMAX = 1023;

  logic            clk = 1'b0;
  logic            clear, start;
  logic [N-1:0]    press;
  logic            go, round_done;
  logic [1:0]      state;
  logic [N*TW-1:0] react_time;
  logic [N-1:0]    valid, false_start, winner;
  logic [TW-1:0]   win_time, best_time;

  reaction_core #(.N_PLAYERS(N), .TW(TW), .TICK_DIV(TD), .DELAY_MIN(DMIN), .DELAY_MASK(16'h0000)) dut (
    .clk(clk), .clear(clear), .start(start), .press(press), .go(go), .state(state),
    .react_time(react_time), .valid(valid), .false_start(false_start), .winner(winner),
    .win_time(win_time), .best_time(best_time), .round_done(round_done)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int rd_count = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h expected=%0h", name, got, exp);
  endtask

  // Model: phase (0 idle,1 wait,2 go,3 done) and cycle offset within the phase.
  bit           m_ok = 0;
  int           m_state, m_k, m_d, m_wt, m_best;
  logic [N-1:0] m_valid, m_fs, m_win, m_pp;
  logic [TW-1:0] m_rt [N];
  logic         m_sp, m_armed;

  task model_step();
    logic [N-1:0] pe, caps;
    int t;
    bit found;
    if (clear) begin
      m_state = 0; m_k = 0; m_d = 0; m_wt = 0; m_best = TMAX;
      m_valid = '0; m_fs = '0; m_win = '0; m_pp = '0; m_sp = 1'b0;
      for (int i = 0; i < N; i++) m_rt[i] = '0;
      m_armed = ~start;
      m_ok = 1;
      return;
    end
    pe = press & ~m_pp;
    case (m_state)
      0: if (start && !m_sp && m_armed) begin
        m_valid = '0; m_fs = '0; m_win = '0; m_wt = 0;
        for (int i = 0; i < N; i++) m_rt[i] = '0;
        m_d = DMIN; m_state = 1; m_k = 0;
      end
      1: begin
        m_fs = m_fs | pe;
        if (m_fs == '1) m_state = 3;
        else if ((m_d == 0) ? (m_k == 0) : (m_k == TD * m_d - 1)) begin m_state = 2; m_k = 0; end
        else m_k++;
      end
      2: begin
        t = m_k / TD;
        if (t > TMAX) t = TMAX;
        caps = pe & ~m_valid & ~m_fs;
        for (int i = 0; i < N; i++) if (caps[i]) m_rt[i] = TW'(t);
        m_valid = m_valid | caps;
        if (m_win == '0 && caps != '0) begin
          found = 0;
          for (int i = 0; i < N; i++)
            if (caps[i] && !found) begin m_win = N'(1 << i); found = 1; end
          m_wt = t;
        end
        if ((m_valid | m_fs) == '1 || t == TMAX) m_state = 3;
        else m_k++;
      end
      default: begin
        if (m_win != '0 && m_wt < m_best) m_best = m_wt;
        m_state = 0;
      end
    endcase
    m_sp = start;
    m_pp = press;
    m_armed = m_armed | ~start;
  endtask

  task compare_outputs();
    logic [N*TW-1:0] exp_rt;
    for (int i = 0; i < N; i++) exp_rt[i*TW +: TW] = m_rt[i];
    check("state", state, m_state);
    check("go", go, m_state == 2);
    check("round_done", round_done, m_state == 3);
    check("valid", valid, m_valid);
    check("false_start", false_start, m_fs);
    check("winner", winner, m_win);
    check("win_time", win_time, m_wt);
    check("best_time", best_time, m_best);
    check("react_time", react_time, exp_rt);
  endtask

  always @(negedge clk) begin
    if (m_ok) begin
      compare_outputs();
      if (round_done === 1'b1) rd_count++;
    end
    model_step();
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int target, input int budget);
    for (int n = 0; n < budget; n++) begin
      if (state == 2'(target)) return;
      cyc(1);
    end
    check("wait_state_timeout", state, target);
  endtask

  task automatic win_round(input int t);
    start = 1; cyc(1); start = 0;
    wait_state(2, 100);
    cyc(TD * t);
    press = '1; cyc(1); press = '0;
    check("lit_allhit_done", state, 3);
    cyc(1);
    check("lit_allhit_winner", winner, 4'b0001);
    check("lit_allhit_wt", win_time, t);
  endtask

  int rd0;

  initial begin
    clear = 1; start = 0; press = '0;
    cyc(3); clear = 0; cyc(2);
    check("lit_reset_state", state, 0);
    check("lit_reset_best", best_time, 10'h3FF);
    check("lit_reset_go", go, 0);

    // single hit at tick 9, others time out
    rd0 = rd_count;
    start = 1; cyc(1); start = 0;
    wait_state(2, 100);
    cyc(36); press = 4'b0100; cyc(1); press = '0;
    wait_state(3, 5000);
    cyc(1);
    check("lit_033_rt2", react_time[2*TW +: TW], 9);
    check("lit_033_winner", winner, 4'b0100);
    check("lit_033_wt", win_time, 9);
    check("lit_033_best", best_time, 9);
    check("lit_033_valid", valid, 4'b0100);
    check("lit_033_pulses", rd_count - rd0, 1);

    // simultaneous first hits: lowest index wins
    start = 1; cyc(1); start = 0;
    wait_state(2, 100);
    cyc(20); press = 4'b1010; cyc(1); press = '0;
    cyc(7); press = 4'b0101; cyc(1); press = '0;
    check("lit_034_done", state, 3);
    cyc(1);
    check("lit_034_winner", winner, 4'b0010);
    check("lit_034_wt", win_time, 5);
    check("lit_034_valid", valid, 4'b1111);

    // false start excludes player 0
    start = 1; cyc(1); start = 0;
    cyc(2); press = 4'b0001; cyc(1); press = '0;
    wait_state(2, 100);
    press = 4'b0001; cyc(1); press = '0;
    cyc(15); press = 4'b0010; cyc(1); press = '0;
    cyc(7); press = 4'b1100; cyc(1); press = '0;
    check("lit_035_done", state, 3);
    cyc(1);
    check("lit_035_fs", false_start, 4'b0001);
    check("lit_035_valid", valid, 4'b1110);
    check("lit_035_winner", winner, 4'b0010);
    check("lit_035_wt", win_time, 4);

    // everyone jumps the gun
    start = 1; cyc(1); start = 0;
    cyc(2); press = 4'b1111; cyc(1); press = '0;
    check("lit_036_done", state, 3);
    cyc(1);
    check("lit_036_winner", winner, 0);
    check("lit_036_best", best_time, 4);
    check("lit_036_fs", false_start, 4'b1111);

    // best time tracking
    clear = 1; cyc(2); clear = 0; cyc(1);
    win_round(9);  check("lit_037_best_a", best_time, 9);
    win_round(12); check("lit_037_best_b", best_time, 9);
    win_round(4);  check("lit_037_best_c", best_time, 4);

    // clear mid-GO with start held high
    start = 1; cyc(1); start = 0;
    wait_state(2, 100);
    cyc(12);
    rd0 = rd_count;
    clear = 1; start = 1; cyc(1); clear = 0;
    check("lit_038_state", state, 0);
    check("lit_038_go", go, 0);
    check("lit_038_valid", valid, 0);
    check("lit_038_best", best_time, 10'h3FF);
    check("lit_038_rd", round_done, 0);
    cyc(5);
    check("lit_038_held", state, 0);
    check("lit_038_no_pulse", rd_count - rd0, 0);
    start = 0; cyc(1); start = 1; cyc(1);
    check("lit_038_restart", state, 1);
    start = 0;

    // randomized play
    clear = 1; cyc(1); clear = 0;
    for (int c = 0; c < 20000; c++) begin
      if ($urandom_range(0, 15) == 0) start = ~start;
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 11) == 0) press[i] = ~press[i];
      clear = ($urandom_range(0, 2999) == 0);
      cyc(1);
    end
    clear = 0;
    cyc(2);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=running expected=finished");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
    $fatal(1);
  end
endmodule
